// File: rtl/mcu_pkg.sv
// Shared MCU definitions: sequencer states, opcode constants, register-bank
// read-enable encodings and immediate sign-extension helpers.
package mcu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        DECODE,
        READ,
        ISSUE,
        HALT
    } state_t;

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_HALT = 4'b1111;

    localparam logic [1:0] LDREGF_IDLE = 2'b00;
    localparam logic [1:0] LDREGF_RD   = 2'b01;

    function automatic logic [15:0] sext8to16(input logic [7:0] v);
        return {{8{v[7]}}, v};
    endfunction

    function automatic logic [15:0] sext5to16(input logic [4:0] v);
        return {{11{v[4]}}, v};
    endfunction

endpackage

// File: rtl/ir_field_split.sv
// Purely combinational split of a 16-bit instruction word into its fields.
module ir_field_split
    import mcu_pkg::*;
(
    input  logic [15:0] ir,
    output logic [3:0]  opcode,
    output logic [2:0]  dr,
    output logic [2:0]  sr1,
    output logic [2:0]  sr2,
    output logic [15:0] imm,
    output logic        imm_sel
);

    assign opcode  = ir[15:12];
    assign dr      = ir[11:9];
    assign sr1     = ir[8:6];
    assign sr2     = ir[2:0];
    assign imm     = sext5to16(ir[4:0]);
    assign imm_sel = ir[5];

endmodule

// File: rtl/instr_decode_seq.sv
// Fetch/decode sequencer: owns PC and IR, reads operands from the register
// bank and hands each decoded op to execute over a valid/done handshake.
module instr_decode_seq
    import mcu_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [3:0]  HALT_OP  = OP_HALT
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        RUN,
    output logic [15:0] MAR,
    output logic        LDMAR,
    input  logic [15:0] MDR,
    output logic [2:0]  REGISTER1,
    output logic [2:0]  REGISTER2,
    output logic [1:0]  LDREGF,
    output logic [3:0]  OPCODE,
    output logic [2:0]  DR,
    output logic [15:0] IMM,
    output logic        IMM_SEL,
    output logic        DEC_VALID,
    input  logic        EXEC_DONE,
    input  logic        PC_LD,
    input  logic [15:0] PC_IN,
    output logic        HALTED
);

    state_t      state_reg, state_next;
    logic [15:0] pc_reg, pc_next;
    logic [15:0] ir_reg, ir_next;
    logic        regs_en;

    logic [3:0]  f_opcode;
    logic [2:0]  f_dr, f_sr1, f_sr2;
    logic [15:0] f_imm;
    logic        f_imm_sel;

    ir_field_split u_split (
        .ir      (ir_reg),
        .opcode  (f_opcode),
        .dr      (f_dr),
        .sr1     (f_sr1),
        .sr2     (f_sr2),
        .imm     (f_imm),
        .imm_sel (f_imm_sel)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= IDLE;
            pc_reg    <= RESET_PC;
            ir_reg    <= 16'h0000;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            ir_reg    <= ir_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        ir_next    = ir_reg;
        LDMAR      = 1'b0;
        LDREGF     = LDREGF_IDLE;
        DEC_VALID  = 1'b0;
        HALTED     = 1'b0;
        regs_en    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (RUN) state_next = FETCH;
            end
            FETCH: begin
                LDMAR      = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                ir_next    = MDR;
                pc_next    = pc_reg + 16'd1;
                state_next = DECODE;
            end
            DECODE: begin
                regs_en    = 1'b1;
                state_next = (f_opcode == HALT_OP) ? HALT : READ;
            end
            READ: begin
                regs_en    = 1'b1;
                LDREGF     = LDREGF_RD;
                state_next = ISSUE;
            end
            ISSUE: begin
                regs_en   = 1'b1;
                DEC_VALID = 1'b1;
                if (EXEC_DONE) begin
                    // A taken branch replaces the sequential PC bumped in WAIT.
                    if (PC_LD) pc_next = PC_IN;
                    state_next = RUN ? FETCH : IDLE;
                end
            end
            HALT: begin
                HALTED = 1'b1;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign MAR       = pc_reg;
    assign REGISTER1 = regs_en ? f_sr1 : 3'd0;
    assign REGISTER2 = regs_en ? f_sr2 : 3'd0;
    assign OPCODE    = DEC_VALID ? f_opcode : 4'd0;
    assign DR        = DEC_VALID ? f_dr : 3'd0;
    assign IMM       = DEC_VALID ? f_imm : 16'h0000;
    assign IMM_SEL   = DEC_VALID ? f_imm_sel : 1'b0;

endmodule

// File: tb/tb_instr_decode_seq.sv
// Directed bench for instr_decode_seq with a ROM model and an expected-op
// scoreboard checked on register reads and on execute handshakes.
module tb_instr_decode_seq;

    logic        CLK = 1'b0;
    logic        RST, RUN, EXEC_DONE, PC_LD;
    logic [15:0] PC_IN;
    logic [15:0] MAR, MDR, IMM;
    logic        LDMAR, DEC_VALID, IMM_SEL, HALTED;
    logic [2:0]  REGISTER1, REGISTER2, DR;
    logic [1:0]  LDREGF;
    logic [3:0]  OPCODE;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [3:0]  op;
        logic [2:0]  dr;
        logic [2:0]  sr1;
        logic [2:0]  sr2;
        logic [15:0] imm;
        logic        sel;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    logic [15:0] rom [0:65535];

    always #5 CLK = ~CLK;

    instr_decode_seq dut (
        .CLK       (CLK),
        .RST       (RST),
        .RUN       (RUN),
        .MAR       (MAR),
        .LDMAR     (LDMAR),
        .MDR       (MDR),
        .REGISTER1 (REGISTER1),
        .REGISTER2 (REGISTER2),
        .LDREGF    (LDREGF),
        .OPCODE    (OPCODE),
        .DR        (DR),
        .IMM       (IMM),
        .IMM_SEL   (IMM_SEL),
        .DEC_VALID (DEC_VALID),
        .EXEC_DONE (EXEC_DONE),
        .PC_LD     (PC_LD),
        .PC_IN     (PC_IN),
        .HALTED    (HALTED)
    );

    // ROM answers the cycle after the address strobe
    always @(posedge CLK) begin
        if (LDMAR) MDR <= rom[MAR];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // sel: 0 = DEC_VALID, 1 = register read, 2 = HALTED
    task automatic wait_sig(input int sel, input string tag);
        int  n;
        logic hit;
        n   = 0;
        hit = 1'b0;
        while (!hit && n < 20) begin
            tick();
            n++;
            case (sel)
                0:       hit = DEC_VALID;
                1:       hit = (LDREGF == 2'b01);
                default: hit = HALTED;
            endcase
        end
        if (!hit) begin
            tests++;
            fails++;
            $error("FAIL %s timeout observed=0 expected=1", tag);
        end
    endtask

    task automatic push(input logic [3:0] op, input logic [2:0] dr, input logic [2:0] s1,
                        input logic [2:0] s2, input logic [15:0] imm, input logic sel);
        exp_t x;
        x = '{op: op, dr: dr, sr1: s1, sr2: s2, imm: imm, sel: sel};
        exp_q.push_back(x);
    endtask

    task automatic do_reset();
        RST = 1'b1; RUN = 1'b0; EXEC_DONE = 1'b0; PC_LD = 1'b0; PC_IN = 16'h0000;
        tick();
        tick();
        RST = 1'b0;
    endtask

    always @(negedge CLK) begin
        if (!RST) begin
            if (LDREGF == 2'b01) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $error("FAIL sb_read unexpected read observed=%0h expected=none", REGISTER1);
                end else begin
                    check("sb_sr1", {29'd0, REGISTER1}, {29'd0, exp_q[0].sr1});
                    check("sb_sr2", {29'd0, REGISTER2}, {29'd0, exp_q[0].sr2});
                end
            end
            if (DEC_VALID && EXEC_DONE) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $error("FAIL sb_issue unexpected op observed=%0h expected=none", OPCODE);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_opcode", {28'd0, OPCODE}, {28'd0, e.op});
                    check("sb_dr", {29'd0, DR}, {29'd0, e.dr});
                    check("sb_imm", {16'd0, IMM}, {16'd0, e.imm});
                    check("sb_imm_sel", {31'd0, IMM_SEL}, {31'd0, e.sel});
                end
            end
        end
    end

    initial begin
        MDR = 16'h0000;
        for (int i = 0; i < 65536; i++) rom[i] = 16'h0000;

        // reset state
        do_reset();
        check("rst_mar", {16'd0, MAR}, 32'h0);
        check("rst_ldmar", {31'd0, LDMAR}, 32'h0);
        check("rst_ldregf", {30'd0, LDREGF}, 32'h0);
        check("rst_dec_valid", {31'd0, DEC_VALID}, 32'h0);
        check("rst_halted", {31'd0, HALTED}, 32'h0);
        check("rst_opcode", {28'd0, OPCODE}, 32'h0);
        check("rst_reg1", {29'd0, REGISTER1}, 32'h0);

        // basic fetch/decode/issue, back-to-back
        rom[0] = 16'h1283;
        rom[1] = 16'h3C0A;
        push(4'd1, 3'd1, 3'd2, 3'd3, 16'h0003, 1'b0);
        push(4'd3, 3'd6, 3'd0, 3'd2, 16'h000A, 1'b0);
        RUN = 1'b1; EXEC_DONE = 1'b1;
        tick();
        check("t1_fetch_ldmar", {31'd0, LDMAR}, 32'h1);
        check("t1_fetch_mar", {16'd0, MAR}, 32'h0);
        wait_sig(1, "t1_read");
        check("t1_ldregf", {30'd0, LDREGF}, 32'h1);
        check("t1_reg1", {29'd0, REGISTER1}, 32'h2);
        check("t1_reg2", {29'd0, REGISTER2}, 32'h3);
        tick();
        check("t1_dec_valid", {31'd0, DEC_VALID}, 32'h1);
        check("t1_opcode", {28'd0, OPCODE}, 32'h1);
        check("t1_dr", {29'd0, DR}, 32'h1);
        tick();
        check("t1_next_ldmar", {31'd0, LDMAR}, 32'h1);
        check("t1_next_mar", {16'd0, MAR}, 32'h1);
        RUN = 1'b0;
        wait_sig(0, "t1_second_issue");
        tick();
        check("t1_idle_dec_valid", {31'd0, DEC_VALID}, 32'h0);
        tick();
        check("t1_idle_ldmar", {31'd0, LDMAR}, 32'h0);
        check("t1_queue_empty", exp_q.size(), 32'h0);

        // immediate form with negative imm5
        do_reset();
        rom[0] = 16'h127F;
        push(4'd1, 3'd1, 3'd1, 3'd7, 16'hFFFF, 1'b1);
        RUN = 1'b1; EXEC_DONE = 1'b1;
        wait_sig(0, "t2_issue");
        check("t2_imm", {16'd0, IMM}, 32'hFFFF);
        check("t2_imm_sel", {31'd0, IMM_SEL}, 32'h1);
        RUN = 1'b0;
        tick();

        // execute stall holds everything
        do_reset();
        rom[0] = 16'h1283;
        push(4'd1, 3'd1, 3'd2, 3'd3, 16'h0003, 1'b0);
        RUN = 1'b1; EXEC_DONE = 1'b0;
        wait_sig(0, "t3_issue");
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_dec_valid", {31'd0, DEC_VALID}, 32'h1);
            check("t3_opcode", {28'd0, OPCODE}, 32'h1);
            check("t3_imm", {16'd0, IMM}, 32'h0003);
            check("t3_reg1", {29'd0, REGISTER1}, 32'h2);
            check("t3_ldmar", {31'd0, LDMAR}, 32'h0);
            check("t3_pc", {16'd0, MAR}, 32'h1);
        end
        EXEC_DONE = 1'b1; RUN = 1'b0;
        tick();
        check("t3_release", {31'd0, DEC_VALID}, 32'h0);

        // redirect: ignored in READ, honoured with EXEC_DONE in ISSUE
        do_reset();
        rom[0]     = 16'h1283;
        rom[16'h40] = 16'h3C0A;
        push(4'd1, 3'd1, 3'd2, 3'd3, 16'h0003, 1'b0);
        push(4'd3, 3'd6, 3'd0, 3'd2, 16'h000A, 1'b0);
        RUN = 1'b1; EXEC_DONE = 1'b1;
        wait_sig(1, "t4_read");
        PC_LD = 1'b1; PC_IN = 16'h0080;
        tick();
        PC_IN = 16'h0040;
        tick();
        check("t4_redirect_mar", {16'd0, MAR}, 32'h0040);
        check("t4_redirect_ldmar", {31'd0, LDMAR}, 32'h1);
        PC_LD = 1'b0; RUN = 1'b0;
        wait_sig(0, "t4_issue");
        tick();
        check("t4_pc_after", {16'd0, MAR}, 32'h0041);

        // PC wrap after redirect to FFFF, then HALT
        do_reset();
        rom[0]        = 16'h1283;
        rom[1]        = 16'hF000;
        rom[16'hFFFF] = 16'h3C0A;
        push(4'd1, 3'd1, 3'd2, 3'd3, 16'h0003, 1'b0);
        push(4'd3, 3'd6, 3'd0, 3'd2, 16'h000A, 1'b0);
        push(4'd1, 3'd1, 3'd2, 3'd3, 16'h0003, 1'b0);
        RUN = 1'b1; EXEC_DONE = 1'b1;
        wait_sig(0, "t5_issue0");
        PC_LD = 1'b1; PC_IN = 16'hFFFF;
        tick();
        PC_LD = 1'b0;
        check("t5_mar_ffff", {16'd0, MAR}, 32'hFFFF);
        wait_sig(0, "t5_issue_ffff");
        check("t5_pc_wrap", {16'd0, MAR}, 32'h0000);
        wait_sig(2, "t5_halt");
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t5_halted", {31'd0, HALTED}, 32'h1);
            check("t5_halt_ldmar", {31'd0, LDMAR}, 32'h0);
            check("t5_halt_dec_valid", {31'd0, DEC_VALID}, 32'h0);
        end
        check("t5_queue_empty", exp_q.size(), 32'h0);

        // reset during READ discards the op
        do_reset();
        rom[0] = 16'h1283;
        push(4'd1, 3'd1, 3'd2, 3'd3, 16'h0003, 1'b0);
        RUN = 1'b1; EXEC_DONE = 1'b1;
        wait_sig(1, "t6_read");
        RST = 1'b1;
        tick();
        check("t6_ldregf", {30'd0, LDREGF}, 32'h0);
        check("t6_dec_valid", {31'd0, DEC_VALID}, 32'h0);
        check("t6_mar", {16'd0, MAR}, 32'h0);
        check("t6_reg1", {29'd0, REGISTER1}, 32'h0);
        check("t6_halted", {31'd0, HALTED}, 32'h0);
        exp_q.delete();
        RUN = 1'b0;
        RST = 1'b0;
        tick();
        tick();
        check("t6_idle_ldmar", {31'd0, LDMAR}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
